// File: rtl/axi_slave_pkg.sv
// Shared constants and FSM state types for the AXI3 SRAM slave.
// LFSR_SEED is only consumed when AXI_SLAVE_RAND_STALL_EN is defined.
package axi_slave_pkg;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // Beats wider than the 32-bit data bus cannot be served.
    function automatic logic size_err(input logic [2:0] size);
        return size > 3'd2;
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the SRAM slave.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_slave_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts (reserved code behaves as INCR).
module axi_slave_addr_gen
    import axi_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);
    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    always_comb begin
        step      = 32'd1 << size;
        incr_addr = addr + step;
        // Wrap block is (len+1)*step bytes, aligned to its own size.
        wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            FIXED:   next_addr = addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave with word-addressed SRAM; independent read and write FSMs, one transaction each.
// Optional AXI_SLAVE_RAND_STALL_EN adds LFSR-driven ready/valid stalls.
//   state  | meaning
//   R_IDLE | arready high, waiting for AR
//   R_DATA | streaming R beats of the latched burst
//   W_IDLE | awready high, waiting for AW
//   W_DATA | accepting W beats until wlast
//   W_RESP | presenting B until bready
module axi_sram_slave
   import axi_slave_pkg::*;
#(
   parameter int    MEM_AW    = 12,
   parameter string INIT_FILE = ""
) (
   input  logic             aclk,
   input  logic             areset,
   axi_sram_slave_if.slave  s
);
   logic [31:0] mem [2**MEM_AW];

   logic rdy_ok;
   logic vld_ok;

`ifdef AXI_SLAVE_RAND_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   always_ff @(posedge aclk) begin
      if (areset) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end
   assign rdy_ok = lfsr_q[0];
   assign vld_ok = ~(lfsr_q[1] & lfsr_q[0]);
`else
   assign rdy_ok = 1'b1;
   assign vld_ok = 1'b1;
`endif

   rd_state_e   r_state_q, r_state_d;
   logic [3:0]  r_id_q,    r_id_d;
   logic [31:0] r_addr_q,  r_addr_d;
   logic [7:0]  r_len_q,   r_len_d;
   logic [2:0]  r_size_q,  r_size_d;
   logic [1:0]  r_burst_q, r_burst_d;
   logic [7:0]  r_cnt_q,   r_cnt_d;
   logic [31:0] r_next;
   logic        r_active;
   logic        r_err;

   axi_slave_addr_gen u_rd_addr (
      .addr(r_addr_q), .size(r_size_q), .len(r_len_q), .burst(r_burst_q), .next_addr(r_next)
   );

   // Outputs are forced to zero while areset is high, including the cycle it is first seen.
   assign r_active  = ~areset & (r_state_q == R_DATA);
   assign r_err     = size_err(r_size_q);
   assign s.arready = ~areset & (r_state_q == R_IDLE) & rdy_ok;
   assign s.rvalid  = r_active & vld_ok;
   assign s.rid     = r_active ? r_id_q : 4'd0;
   assign s.rlast   = r_active & (r_cnt_q == r_len_q);
   assign s.rresp   = (r_active & r_err) ? SLVERR : OKAY;
   assign s.rdata   = (r_active & ~r_err) ? mem[r_addr_q[MEM_AW+1:2]] : 32'd0;

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_cnt_d   = r_cnt_q;
      case (r_state_q)
         R_IDLE: if (s.arvalid & s.arready) begin
            r_id_d    = s.arid;
            r_addr_d  = s.araddr;
            r_len_d   = s.arlen;
            r_size_d  = s.arsize;
            r_burst_d = s.arburst;
            r_cnt_d   = 8'd0;
            r_state_d = R_DATA;
         end
         R_DATA: if (s.rvalid & s.rready) begin
            r_addr_d = r_next;
            r_cnt_d  = r_cnt_q + 8'd1;
            if (s.rlast) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_cnt_q   <= r_cnt_d;
      end
   end

   wr_state_e   w_state_q, w_state_d;
   logic [3:0]  w_id_q,    w_id_d;
   logic [31:0] w_addr_q,  w_addr_d;
   logic [7:0]  w_len_q,   w_len_d;
   logic [2:0]  w_size_q,  w_size_d;
   logic [1:0]  w_burst_q, w_burst_d;
   logic [8:0]  w_cnt_q,   w_cnt_d;
   logic        w_err_q,   w_err_d;
   logic [31:0] w_next;
   logic        w_resp;
   logic        w_beat_ok;
   logic        mem_we;

   axi_slave_addr_gen u_wr_addr (
      .addr(w_addr_q), .size(w_size_q), .len(w_len_q), .burst(w_burst_q), .next_addr(w_next)
   );

   assign w_resp    = ~areset & (w_state_q == W_RESP);
   assign s.awready = ~areset & (w_state_q == W_IDLE) & rdy_ok;
   assign s.wready  = ~areset & (w_state_q == W_DATA) & rdy_ok;
   assign s.bvalid  = w_resp & vld_ok;
   assign s.bid     = w_resp ? w_id_q : 4'd0;
   assign s.bresp   = (w_resp & w_err_q) ? SLVERR : OKAY;

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      w_beat_ok = 1'b0;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (s.awvalid & s.awready) begin
            w_id_d    = s.awid;
            w_addr_d  = s.awaddr;
            w_len_d   = s.awlen;
            w_size_d  = s.awsize;
            w_burst_d = s.awburst;
            w_cnt_d   = 9'd0;
            w_err_d   = size_err(s.awsize);
            w_state_d = W_DATA;
         end
         W_DATA: if (s.wvalid & s.wready) begin
            w_beat_ok = ~size_err(w_size_q) & (s.wid == w_id_q) & (w_cnt_q <= {1'b0, w_len_q});
            mem_we    = w_beat_ok;
            if (!w_beat_ok) w_err_d = 1'b1;
            w_addr_d = w_next;
            // Saturate so a runaway burst never wraps back into the legal beat range.
            if (w_cnt_q != 9'h1FF) w_cnt_d = w_cnt_q + 9'd1;
            if (s.wlast) w_state_d = W_RESP;
         end
         W_RESP: if (s.bvalid & s.bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
      end
   end

   // Memory is deliberately outside the reset domain.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (s.wstrb[b]) mem[w_addr_q[MEM_AW+1:2]][8*b +: 8] <= s.wdata[8*b +: 8];
         end
      end
   end

   logic unused_ok;
   assign unused_ok = ^{s.arlock, s.arcache, s.arprot, s.awlock, s.awcache, s.awprot};

endmodule
